// File: rtl/modexp_arbiter.sv
// modexp_arbiter: round-robin sharing of one mod_exp engine with reset/start sequencing and watchdog
module modexp_arbiter #(
  parameter int LEN     = 64,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*LEN-1:0] req_base_i,
  input  logic [NREQ*LEN-1:0] req_exp_i,
  input  logic [NREQ*LEN-1:0] req_mod_i,
  output logic [NREQ-1:0]     rsp_valid_o,
  output logic [LEN-1:0]      rsp_data_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  output logic                eng_rst_o,
  output logic                eng_start_o,
  output logic [LEN-1:0]      eng_base_o,
  output logic [LEN-1:0]      eng_exp_o,
  output logic [LEN-1:0]      eng_mod_o,
  input  logic [LEN-1:0]      eng_out_i,
  input  logic                eng_done_i
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d, last_q, last_d, sel;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]  base_q, base_d, exp_q, exp_d, mod_q, mod_d, data_q, data_d;
  logic            err_q, err_d, found;
  // round-robin pick: first valid requester after the last one served, wrapping
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && state_q == IDLE && req_valid_i[(int'(last_q) + k) % NREQ]) begin
        sel   = IW'((int'(last_q) + k) % NREQ);
        found = 1'b1;
      end
    end
    req_ready_o = found ? NREQ'(1) << sel : '0;
  end
  // next-state and datapath updates; a zero modulus skips the engine entirely
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (found) begin
        owner_d = sel;
        base_d  = req_base_i[int'(sel)*LEN +: LEN];
        exp_d   = req_exp_i[int'(sel)*LEN +: LEN];
        mod_d   = req_mod_i[int'(sel)*LEN +: LEN];
        err_d   = |mod_d ? err_q : 1'b1;
        state_d = |mod_d ? LOAD : RESP;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (eng_done_i) begin
          data_d  = eng_out_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
    endcase
  end
  // state registers, asynchronously cleared so the engine is held in reset at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  assign rsp_valid_o = state_q == RESP ? NREQ'(1) << owner_q : '0;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = state_q != IDLE;
  assign eng_rst_o   = state_q != RUN;
  assign eng_start_o = state_q == RUN;
  assign eng_base_o  = base_q;
  assign eng_exp_o   = exp_q;
  assign eng_mod_o   = mod_q;
endmodule

// File: tb/tb_modexp_arbiter.sv
// tb_modexp_arbiter: transaction-level model plus directed scenarios for the engine arbiter
module tb_modexp_arbiter;
  localparam int LEN = 64, NREQ = 3, TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid_i = '0, req_ready_o, rsp_valid_o;
  logic [NREQ*LEN-1:0] req_base_i = '0, req_exp_i = '0, req_mod_i = '0;
  logic [LEN-1:0] rsp_data_o, eng_base_o, eng_exp_o, eng_mod_o, eng_out_i = '0;
  logic rsp_err_o, busy_o, eng_rst_o, eng_start_o, eng_done_i = 1'b0;
  int n_cmp = 0, n_bad = 0;
  modexp_arbiter #(.LEN(LEN), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_base_i(req_base_i), .req_exp_i(req_exp_i), .req_mod_i(req_mod_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .eng_rst_o(eng_rst_o), .eng_start_o(eng_start_o),
    .eng_base_o(eng_base_o), .eng_exp_o(eng_exp_o), .eng_mod_o(eng_mod_o),
    .eng_out_i(eng_out_i), .eng_done_i(eng_done_i));
  always #5 clk = ~clk;
  function automatic logic [LEN-1:0] modexp(input logic [LEN-1:0] b, e, m);
    logic [127:0] r, x;
    if (m == 0) return '0;
    x = 128'(b) % 128'(m);
    r = 128'(1) % 128'(m);
    for (int i = 0; i < LEN; i++) begin
      if (e[i]) r = (r * x) % 128'(m);
      x = (x * x) % 128'(m);
    end
    return r[LEN-1:0];
  endfunction
  function automatic int rr(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction
  task automatic check(input string nm, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  int dly = 1, run = 0, cyc = 0;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #2;
    if (eng_rst_o) begin
      run = 0;
      eng_done_i = 1'b0;
    end else if (eng_start_o) begin
      run++;
      eng_done_i = run >= dly;
      eng_out_i = modexp(eng_base_o, eng_exp_o, eng_mod_o);
    end
  end
  typedef struct {int idx; logic [LEN-1:0] d; logic e;} rsp_t;
  rsp_t rsp_log[$];
  int acc_log[$];
  bit pend = 0, m_err = 0, exp_err = 0, saw_start = 0;
  int t_acc = 0, m_own = 0, m_rp = 0, m_last = NREQ - 1, g = 0, ph = 0;
  logic [LEN-1:0] m_data = '0, exp_data = '0, mb, me, mm;
  logic [NREQ-1:0] acc = '0, keep = '0;
  always @(negedge clk) begin
    acc = req_valid_i & req_ready_o;
    if (eng_start_o) saw_start = 1;
    if (rst) begin
      pend = 0; m_last = NREQ - 1; m_data = '0; m_err = 0;
      check("rst_ready", LEN'(req_ready_o), 0);
      check("rst_rsp_valid", LEN'(rsp_valid_o), 0);
      check("rst_rsp_data", rsp_data_o, 0);
      check("rst_rsp_err", LEN'(rsp_err_o), 0);
      check("rst_busy", LEN'(busy_o), 0);
      check("rst_eng_rst", LEN'(eng_rst_o), 1);
      check("rst_eng_start", LEN'(eng_start_o), 0);
      check("rst_eng_ops", eng_base_o | eng_exp_o | eng_mod_o, 0);
    end else if (!pend) begin
      g = rr(req_valid_i, m_last);
      check("idle_ready", LEN'(req_ready_o), g < 0 ? 0 : LEN'(1) << g);
      check("idle_busy", LEN'(busy_o), 0);
      check("idle_eng_rst", LEN'(eng_rst_o), 1);
      check("idle_eng_start", LEN'(eng_start_o), 0);
      check("idle_rsp_valid", LEN'(rsp_valid_o), 0);
      check("idle_rsp_data", rsp_data_o, m_data);
      check("idle_rsp_err", LEN'(rsp_err_o), LEN'(m_err));
      if (g >= 0) begin
        pend = 1; t_acc = cyc; m_own = g; acc_log.push_back(g);
        mb = req_base_i[g*LEN +: LEN]; me = req_exp_i[g*LEN +: LEN]; mm = req_mod_i[g*LEN +: LEN];
        if (mm == 0) begin
          m_rp = 1; exp_err = 1; exp_data = m_data;
        end else if (dly <= TO) begin
          m_rp = 2 + dly; exp_err = 0; exp_data = modexp(mb, me, mm);
        end else begin
          m_rp = 2 + TO; exp_err = 1; exp_data = '0;
        end
      end
    end else begin
      ph = cyc - t_acc;
      check("busy_ready", LEN'(req_ready_o), 0);
      check("busy_busy", LEN'(busy_o), 1);
      if (ph == m_rp) begin
        check("rsp_valid", LEN'(rsp_valid_o), LEN'(1) << m_own);
        check("rsp_data", rsp_data_o, exp_data);
        check("rsp_err", LEN'(rsp_err_o), LEN'(exp_err));
        check("rsp_eng_rst", LEN'(eng_rst_o), 1);
        check("rsp_eng_start", LEN'(eng_start_o), 0);
        rsp_log.push_back('{m_own, rsp_data_o, rsp_err_o});
        m_data = exp_data; m_err = exp_err; m_last = m_own; pend = 0;
      end else begin
        check("run_rsp_valid", LEN'(rsp_valid_o), 0);
        check("run_rsp_data", rsp_data_o, m_data);
        check("run_rsp_err", LEN'(rsp_err_o), LEN'(m_err));
        check("run_eng_rst", LEN'(eng_rst_o), ph >= 2 ? 0 : 1);
        check("run_eng_start", LEN'(eng_start_o), ph >= 2 ? 1 : 0);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid_i = req_valid_i & ~(acc & ~keep);
  endtask
  task automatic put(input int i, input logic [LEN-1:0] b, e, m);
    req_base_i[i*LEN +: LEN] = b;
    req_exp_i[i*LEN +: LEN] = e;
    req_mod_i[i*LEN +: LEN] = m;
    req_valid_i[i] = 1'b1;
  endtask
  task automatic quiet(input string nm);
    int k = 0;
    while ((req_valid_i != 0 || pend) && k < 2000) begin
      tick();
      k++;
    end
    check(nm, LEN'(k < 2000), 1);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    req_valid_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int k, zeros;
    repeat (3) tick();
    rst = 1'b0;
    dly = 2;
    put(1, 5, 6, 23);
    #1 check("t1_ready_now", LEN'(req_ready_o), 3'b010);
    quiet("t1_done");
    check("t1_count", rsp_log.size(), 1);
    check("t1_idx", rsp_log[0].idx, 1);
    check("t1_data", rsp_log[0].d, 8);
    check("t1_err", LEN'(rsp_log[0].e), 0);
    pulse_rst();
    rsp_log.delete(); acc_log.delete();
    dly = 3;
    put(0, 3, 4, 7); put(1, 2, 10, 1000); put(2, 7, 2, 5);
    quiet("t2_done");
    check("t2_count", rsp_log.size(), 3);
    check("t2_order0", acc_log[0], 0);
    check("t2_order1", acc_log[1], 1);
    check("t2_order2", acc_log[2], 2);
    check("t2_data0", rsp_log[0].d, 4);
    check("t2_data1", rsp_log[1].d, 24);
    check("t2_data2", rsp_log[2].d, 4);
    check("t2_idx1", rsp_log[1].idx, 1);
    rsp_log.delete(); acc_log.delete();
    dly = 1; keep = 3'b101;
    put(0, 3, 4, 7); put(2, 7, 2, 5);
    k = 0;
    while (acc_log.size() < 20 && k < 2000) begin
      tick();
      k++;
    end
    keep = '0;
    quiet("t3_done");
    check("t3_rounds", LEN'(acc_log.size() >= 20), 1);
    zeros = 0;
    for (int i = 0; i < 20 && i < acc_log.size(); i++) if (acc_log[i] == 0) zeros++;
    check("t3_first", acc_log[0], 0);
    check("t3_second", acc_log[1], 2);
    check("t3_fair", zeros, 10);
    check("t3_data", rsp_log[1].d, 4);
    rsp_log.delete(); acc_log.delete();
    saw_start = 0;
    put(0, 9, 9, 0);
    quiet("t4_done");
    check("t4_idx", rsp_log[0].idx, 0);
    check("t4_err", LEN'(rsp_log[0].e), 1);
    check("t4_no_start", LEN'(saw_start), 0);
    rsp_log.delete();
    dly = 1000;
    put(2, 3, 3, 11);
    quiet("t5_done");
    check("t5_err", LEN'(rsp_log[0].e), 1);
    check("t5_data", rsp_log[0].d, 0);
    dly = 2;
    put(1, 2, 10, 1000);
    quiet("t5_next");
    check("t5_next_err", LEN'(rsp_log[1].e), 0);
    check("t5_next_data", rsp_log[1].d, 24);
    rsp_log.delete();
    dly = 5;
    put(0, 5, 6, 23);
    k = 0;
    while (!(pend && cyc - t_acc >= 4) && k < 100) begin
      tick();
      k++;
    end
    check("t6_reached_run", LEN'(eng_start_o), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", LEN'(busy_o), 0);
    check("t6_eng_rst", LEN'(eng_rst_o), 1);
    check("t6_eng_start", LEN'(eng_start_o), 0);
    check("t6_rsp_valid", LEN'(rsp_valid_o), 0);
    req_valid_i = '0;
    tick();
    tick();
    rst = 1'b0;
    check("t6_no_rsp", rsp_log.size(), 0);
    dly = 2;
    put(0, 5, 6, 23);
    quiet("t6_done");
    check("t6_idx", rsp_log[0].idx, 0);
    check("t6_data", rsp_log[0].d, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
